// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and constants for the program loader.
package program_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;
  typedef enum logic [3:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, FINISH, CHECK, DONE, ERROR} state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, program-memory write port and status out.
interface program_loader_if #(parameter int DW = 32);
  logic Start, ByteValid, ByteReady, MemWrite, CpuHold, Done, Error;
  logic [7:0] ByteIn;
  logic [DW-1:0] MemAddress, MemData;
  modport master(output Start, ByteIn, ByteValid,
                 input ByteReady, MemWrite, MemAddress, MemData, CpuHold, Done, Error);
  modport slave(input Start, ByteIn, ByteValid,
                output ByteReady, MemWrite, MemAddress, MemData, CpuHold, Done, Error);
endinterface

// File: rtl/program_loader_word_assembler.sv
// word_assembler: shifts stream bytes MSB-first into a word and flags the 4th byte.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        word_full
);
  logic [31:0] word;
  logic [1:0]  cnt;
  assign word_nxt  = {word[23:0], byte_in};
  assign word_full = load && cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      word <= '0;
      cnt  <= '0;
    end else if (clr) begin
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= word_nxt;
      cnt  <= cnt + 2'd1;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a counted byte stream into program memory, holding the CPU until done.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input logic               clk,
  input logic               reset,
  program_loader_if.slave   bus
);
  localparam int IW = $clog2(MEMORY_DEPTH);
  state_t                state;
  logic [15:0]           count;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  word_full;
  logic                  acc, start_ok, last;
  logic [15:0]           n_new;
  assign acc      = bus.ByteValid && bus.ByteReady;
  assign start_ok = bus.Start && (state == IDLE || state == DONE || state == ERROR);
  assign n_new    = {count[15:8], bus.ByteIn};
  assign last     = 16'(idx) + 16'd1 == count;
  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_ok),
    .load      (acc && state == DATA),
    .byte_in   (bus.ByteIn),
    .word_nxt  (word_nxt),
    .word_full (word_full)
  );
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge reset)
    if (!reset) csum <= '0;
    else if (start_ok) csum <= '0;
    else if (acc && state != CHECK) csum <= csum ^ bus.ByteIn;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      idx            <= '0;
      bus.ByteReady  <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.MemAddress <= BASE_ADDRESS;
      bus.MemData    <= '0;
      bus.CpuHold    <= 1'b1;
      bus.Done       <= 1'b0;
      bus.Error      <= 1'b0;
    end else if (start_ok) begin
      state         <= CNT_HI;
      count         <= '0;
      idx           <= '0;
      bus.ByteReady <= 1'b1;
      bus.MemWrite  <= 1'b0;
      bus.CpuHold   <= 1'b1;
      bus.Done      <= 1'b0;
      bus.Error     <= 1'b0;
    end else begin
      bus.MemWrite <= 1'b0;
      case (state)
        CNT_HI: if (acc) begin
          count[15:8] <= bus.ByteIn;
          state       <= CNT_LO;
        end
        CNT_LO: if (acc) begin
          count[7:0]    <= bus.ByteIn;
          state         <= n_new > 16'(MEMORY_DEPTH) ? ERROR : n_new == 16'd0 ? FINISH : DATA;
          bus.ByteReady <= n_new != 16'd0 && n_new <= 16'(MEMORY_DEPTH);
          bus.Error     <= n_new > 16'(MEMORY_DEPTH);
        end
        DATA: if (word_full) begin
          state          <= WRITE;
          bus.ByteReady  <= 1'b0;
          bus.MemWrite   <= 1'b1;
          bus.MemData    <= word_nxt;
          bus.MemAddress <= BASE_ADDRESS + 32'({idx, 2'b00});
        end
        // index stays at the last written word so it never exceeds MEMORY_DEPTH-1
        WRITE: begin
          state         <= last ? FINISH : DATA;
          bus.ByteReady <= !last;
          idx           <= last ? idx : idx + IW'(1);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        FINISH: begin
          state         <= CHECK;
          bus.ByteReady <= 1'b1;
        end
        CHECK: if (acc) begin
          state         <= bus.ByteIn == csum ? DONE : ERROR;
          bus.ByteReady <= 1'b0;
          bus.Done      <= bus.ByteIn == csum;
          bus.Error     <= bus.ByteIn != csum;
          bus.CpuHold   <= bus.ByteIn != csum;
        end
`else
        FINISH: begin
          state       <= DONE;
          bus.Done    <= 1'b1;
          bus.CpuHold <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program-memory interface. Receives a byte stream (e.g. from a UART receiver), assembles 32-bit instruction words, and writes them sequentially into a writable program memory.
- Holds the CPU in reset until a load completes.
- Sits between the serial/debug front end and the instruction memory write port. The CPU fetch path keeps reading the same storage.

Parameters:
- MEMORY_DEPTH, 32, number of instruction words in program memory; maximum accepted word count.
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0 (MIPS text segment).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- ByteIn  input  8  incoming stream byte.
- ByteValid  input  1  ByteIn is valid this cycle.
- ByteReady  output  1  loader accepts a byte this cycle.
- MemWrite  output  1  program-memory write enable, one-cycle pulse per word.
- MemAddress  output  DATA_WIDTH  byte address of the word being written (word aligned).
- MemData  output  DATA_WIDTH  assembled instruction word.
- CpuHold  output  1  1 = CPU held in reset.
- Done  output  1  load finished successfully (level).
- Error  output  1  load aborted (level).

Behaviour:
- Reset (reset==0, async):
  - State IDLE.
  - ByteReady=0, MemWrite=0, MemAddress=BASE_ADDRESS, MemData=0, CpuHold=1, Done=0, Error=0.
  - Internal count, word index, byte index and checksum cleared.
- Byte transfer: a byte is accepted on a rising edge with ByteValid&&ByteReady. ByteReady is 1 only in CNT_HI, CNT_LO, DATA and CHECK. ByteValid with ByteReady=0 is ignored; the sender must hold the byte.
- Stream format: count high byte, count low byte (16-bit word count N), then N×4 data bytes, first byte = MSB (bits 31:24).
- FSM:
  - IDLE: Start -> CNT_HI. Clear Done/Error, word index=0, CpuHold=1.
  - CNT_HI: accept byte -> count[15:8] -> CNT_LO.
  - CNT_LO: accept byte -> count[7:0].
    - N > MEMORY_DEPTH -> ERROR.
    - N == 0 -> FINISH.
    - else -> DATA.
  - DATA: shift the accepted byte into the word register (word = {word[23:0],byte}). After the 4th byte -> WRITE.
  - WRITE (exactly 1 cycle, ByteReady=0):
    - MemWrite=1, MemData=word, MemAddress=BASE_ADDRESS + 4*index.
    - Next cycle index++. If index+1 == N -> FINISH, else -> DATA.
  - FINISH: -> DONE (or -> CHECK with feature).
  - DONE: Done=1, CpuHold=0. Start -> CNT_HI; this re-asserts CpuHold and clears Done in the same transition.
  - ERROR: Error=1, CpuHold=1. Start -> CNT_HI.
- Latency: MemWrite asserts in the cycle after the 4th byte of a word is accepted. Done asserts 2 cycles after the last WRITE cycle (WRITE -> FINISH -> DONE).
- Start outside IDLE/DONE/ERROR is ignored; it does not restart a load in progress.
- Reset mid-load aborts immediately. Words already written remain in memory; CpuHold=1.
- MemAddress and MemData are registered and hold their last values outside WRITE.
- Address arithmetic is modulo 2^32. index never exceeds MEMORY_DEPTH-1.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - FINISH -> CHECK. CHECK accepts one byte.
  - If the byte equals the XOR of all previously accepted bytes (count bytes included) -> DONE, else -> ERROR.
  - Checksum register resets to 0 and clears on Start.
- Undefined: CHECK state and checksum logic are absent; FINISH -> DONE.

Decomposition:
- Shared package program_loader_pkg:
  - state encoding localparams (IDLE, CNT_HI, CNT_LO, DATA, WRITE, FINISH, CHECK, DONE, ERROR)
  - BYTES_PER_WORD=4
  - default BASE_ADDRESS constant
- One natural sub-module: word_assembler (byte shift register plus 2-bit byte counter, with clear and load strobe, and a word_full output).

Test Plan:
- Reset: reset=0 mid-stream -> CpuHold=1, Done=0, Error=0, ByteReady=0, MemAddress=32'h0040_0000.
- Normal load: Start; bytes 00 02 20 08 00 05 AC 08 00 00 -> MemWrite pulses with (0x00400000, 0x20080005) then (0x00400004, 0xAC080000); Done=1, CpuHold=0 two cycles after the second write.
- Backpressure: ByteValid held high continuously -> exactly one byte accepted per ByteReady cycle, no byte lost or duplicated during WRITE.
- Overflow: count 00 21 with MEMORY_DEPTH=32 -> ERROR after the second byte; MemWrite never asserts; Error=1, CpuHold=1.
- Zero count / restart: count 00 00 -> DONE with no writes; then Start -> Done drops, CpuHold=1, a new load proceeds. A Start pulse during DATA is ignored.
- Checksum (macro defined): stream 00 01 12 34 56 78 plus checksum byte 0x09 -> DONE. Same stream with checksum 0x00 -> ERROR, after the single write to 0x00400000 has occurred.
